// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver so that
// both ends agree on state encoding, default bit timing and frame framing bits.
package uart_pkg;

  typedef enum logic {
    IDLE         = 1'b0,
    TRANSMITTING = 1'b1
  } uart_state_e;

  localparam int   BAUD_DIV_DEFAULT  = 2604;
  localparam int   DATA_BITS_DEFAULT = 8;
  localparam int   FRAME_BITS        = DATA_BITS_DEFAULT + 2;
  localparam logic START_BIT         = 1'b0;
  localparam logic STOP_BIT          = 1'b1;

  function automatic int frame_len(input int data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side handshake and serial output of the UART transmitter.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT
);

  logic                 trmt;
  logic [DATA_BITS-1:0] tx_data;
  logic                 TX;
  logic                 busy;
  logic                 tx_done;

  modport master (output trmt, output tx_data, input TX, input busy, input tx_done);
  modport slave  (input trmt, input tx_data, output TX, output busy, output tx_done);

endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: serialises a byte accepted on a trmt strobe as
// start bit, DATA_BITS LSB-first data bits and stop bit, with a sticky tx_done.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = BAUD_DIV_DEFAULT,
  parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int FRAME_W = frame_len(DATA_BITS);
  localparam int BAUD_W  = $clog2(BAUD_DIV);
  localparam int BIT_W   = $clog2(DATA_BITS + 3);

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LOAD    = BIT_W'(FRAME_W);

  uart_state_e          state_q, state_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [BAUD_W-1:0]    baud_q,  baud_d;
  logic [BIT_W-1:0]     bit_q,   bit_d;
  logic                 done_q,  done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (bus.trmt) begin
          shift_d = {STOP_BIT, bus.tx_data, START_BIT};
          baud_d  = BAUD_RELOAD;
          bit_d   = BIT_LOAD;
          done_d  = 1'b0;
          state_d = TRANSMITTING;
        end
      end
      TRANSMITTING: begin
        if (baud_q == '0) begin
          // Shift in ones so the line sits at the idle level once the frame drains.
          shift_d = {1'b1, shift_q[FRAME_W-1:1]};
          baud_d  = BAUD_RELOAD;
          bit_d   = bit_q - BIT_W'(1);
          if (bit_q == BIT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.TX      = shift_q[0];
  assign bus.busy    = (state_q == TRANSMITTING);
  assign bus.tx_done = done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter; companion to the team's UART receiver, with the same bit timing, so a TX→RX loopback is bit-exact.
- Accepts a byte on a single-cycle `trmt` strobe and serialises it on `TX`: start bit (0), 8 data bits LSB-first, stop bit (1).
- Signals frame completion with a sticky `tx_done` flag. Sits between host-side command logic and the board serial pin.

Parameters:
- BAUD_DIV, 2604, clock cycles per bit period (must be ≥ 2).
- DATA_BITS, 8, payload bits per frame; frame length is DATA_BITS+2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- trmt  input  1  start-transmit strobe; sampled every cycle.
- tx_data  input  DATA_BITS  byte to send; captured only in the cycle `trmt` is accepted.
- TX  output  1  serial line; idles high.
- busy  output  1  high while a frame is in flight.
- tx_done  output  1  sticky: set at end of frame, cleared when the next frame is accepted.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, TX=1, busy=0, tx_done=0.
  - Baud and bit counters cleared; shift register loaded all-ones.
  - Reset mid-frame aborts the frame. TX is 1 on the cycle after the reset edge. No `tx_done` is produced for the aborted frame.
- States: IDLE, TRANSMITTING (2-state enum).
- IDLE:
  - If trmt=1, accept the frame: load shift reg with {1'b1, tx_data, 1'b0}, baud_cnt=BAUD_DIV-1, bit_cnt=DATA_BITS+2, clear tx_done, go to TRANSMITTING.
  - Otherwise hold.
- TRANSMITTING:
  - baud_cnt decrements each cycle.
  - When baud_cnt==0: shift right, filling with 1; reload baud_cnt=BAUD_DIV-1; decrement bit_cnt.
  - When that shift brings bit_cnt to 0: go to IDLE and set tx_done.
- TX is registered and always equals shift_reg[0].
- Latency and timing:
  - trmt accepted at edge N → TX=0 (start bit) visible from edge N until edge N+BAUD_DIV.
  - Each bit is held exactly BAUD_DIV cycles; the whole frame occupies 10·BAUD_DIV cycles.
  - tx_done=1 and busy=0 from edge N+10·BAUD_DIV. TX is already 1 at that point (stop bit, then idle).
- busy is 1 exactly while state==TRANSMITTING (registered state decode).
- trmt while busy: ignored; the in-flight frame and tx_data capture are unaffected, and the request is not queued.
- tx_data changing after acceptance has no effect on the current frame.
- trmt in the first IDLE cycle after a frame: accepted. tx_done clears on that same edge; back-to-back frames have zero idle gap.
- Counter widths:
  - baud_cnt = $clog2(BAUD_DIV) bits.
  - bit_cnt = $clog2(DATA_BITS+3) bits.
  - No wrap-around is reachable in legal operation.

Decomposition:
- Shared package uart_pkg holds:
  - the tx/rx state typedef,
  - default BAUD_DIV (2604), shared with the receiver so both ends agree,
  - the FRAME_BITS = DATA_BITS+2 constant,
  - START_BIT=0 and STOP_BIT=1 constants.
- No sub-module; the baud counter is inline. A shared uart_baud_gen is unnecessary for a single instance.

Test Plan (sim with BAUD_DIV=16 unless noted):
1. Reset then idle 100 cycles → TX=1, busy=0, tx_done=0 throughout.
2. trmt with tx_data=8'hA5 → TX sequence 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; tx_done rises exactly 160 cycles after acceptance.
3. trmt=1 again at cycle 40 of a frame with tx_data=8'h00 → ignored; the original 8'hA5 frame is unchanged; no second frame follows.
4. Back-to-back: trmt 8'h3C accepted the cycle tx_done rises, then 8'hFF → second start bit begins immediately with no idle-high gap; tx_done clears on acceptance.
5. rst=1 at cycle 70 of a 8'h55 frame → TX=1, busy=0, tx_done=0 on the next cycle; a subsequent trmt 8'h81 frame is correct.
6. Loopback to the UART receiver at default BAUD_DIV=2604 with bytes 8'h00, 8'hFF, 8'h5A → rx_data matches each byte; rdy asserts once per frame.
